// File: rtl/axis_video_frame_checker.sv
// rtl/axis_video_frame_checker.sv - AXI4-Stream video pass-through with 2-entry skid buffer and frame geometry checker
module axis_video_frame_checker #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                            s00_axis_aclk,
    input  logic                            s00_axis_aresetn,
    input  logic [C_CNT_WIDTH-1:0]          cfg_line_beats,
    input  logic [C_CNT_WIDTH-1:0]          cfg_frame_lines,
    input  logic                            stat_clr,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tuser,
    input  logic                            s00_axis_tlast,
    output logic                            m00_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tuser,
    output logic                            m00_axis_tlast,
    input  logic                            m00_axis_tready,
    output logic [31:0]                     frame_cnt,
    output logic [C_CNT_WIDTH-1:0]          err_frame_cnt,
    output logic [3:0]                      stat_err,
    output logic                            sof_pulse,
    output logic                            in_frame
);

    localparam int SW = C_AXIS_TDATA_WIDTH / 8;
    localparam int PW = C_AXIS_TDATA_WIDTH + SW + 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [PW-1:0] buf_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          accept;
    logic          drain;
    logic [PW-1:0] head;

    assign accept = s00_axis_tvalid & s00_axis_tready;
    assign drain  = m00_axis_tvalid & m00_axis_tready;

    always_comb begin
        count_next = count + {1'b0, accept} - {1'b0, drain};
    end

    // Ready is computed from the post-update fill level, so it is registered yet never overflows.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            buf_q[0]        <= '0;
            buf_q[1]        <= '0;
            rd_ptr          <= 1'b0;
            wr_ptr          <= 1'b0;
            count           <= 2'd0;
            s00_axis_tready <= 1'b0;
        end else begin
            if (accept) begin
                buf_q[wr_ptr] <= {s00_axis_tdata, s00_axis_tstrb, s00_axis_tuser, s00_axis_tlast};
            end
            wr_ptr          <= wr_ptr ^ accept;
            rd_ptr          <= rd_ptr ^ drain;
            count           <= count_next;
            s00_axis_tready <= (count_next != 2'd2);
        end
    end

    assign head            = buf_q[rd_ptr];
    assign m00_axis_tvalid = (count != 2'd0);
    assign m00_axis_tdata  = head[PW-1 -: C_AXIS_TDATA_WIDTH];
    assign m00_axis_tstrb  = head[SW+1:2];
    assign m00_axis_tuser  = head[1];
    assign m00_axis_tlast  = head[0];

    // Accepted upstream beats are staged one cycle before the checker sees them.
    logic obs_valid;
    logic obs_user;
    logic obs_last;

    logic [1:0]             state;
    logic [C_CNT_WIDTH-1:0] beat_idx;
    logic [C_CNT_WIDTH-1:0] line_cnt;
    logic [C_CNT_WIDTH-1:0] lat_lb;
    logic [C_CNT_WIDTH-1:0] lat_fl;
    logic                   frame_bad;

    logic [1:0]             st_n;
    logic [C_CNT_WIDTH-1:0] b_n;
    logic [C_CNT_WIDTH-1:0] line_n;
    logic [C_CNT_WIDTH-1:0] lb_n;
    logic [C_CNT_WIDTH-1:0] fl_n;
    logic                   bad_n;
    logic [3:0]             err_set;
    logic                   good_inc;
    logic [1:0]             bad_inc;
    logic                   sof_n;
    logic [C_CNT_WIDTH:0]   efc_sum;

    always_comb begin
        st_n     = state;
        b_n      = beat_idx;
        line_n   = line_cnt;
        lb_n     = lat_lb;
        fl_n     = lat_fl;
        bad_n    = frame_bad;
        err_set  = 4'b0000;
        good_inc = 1'b0;
        bad_inc  = 2'd0;
        sof_n    = 1'b0;
        if (obs_valid) begin
            if (obs_user) begin
                if (state == ST_ACTIVE) begin
                    err_set[2] = 1'b1;
                    bad_inc    = 2'd1;
                end
                lb_n   = cfg_line_beats;
                fl_n   = cfg_frame_lines;
                b_n    = CNT_ONE;
                line_n = '0;
                bad_n  = 1'b0;
                sof_n  = 1'b1;
                st_n   = ST_ACTIVE;
            end else if (state == ST_DONE) begin
                err_set[3] = 1'b1;
            end
            // The SOF beat falls through here and is checked as beat 1 of the new frame.
            if (st_n == ST_ACTIVE) begin
                if (obs_last && (b_n < lb_n)) begin
                    err_set[0] = 1'b1;
                    bad_n      = 1'b1;
                end
                if (!obs_last && (b_n == lb_n)) begin
                    err_set[1] = 1'b1;
                    bad_n      = 1'b1;
                end
                if (obs_last) begin
                    line_n = line_n + CNT_ONE;
                    b_n    = CNT_ONE;
                    if (line_n == fl_n) begin
                        st_n = ST_DONE;
                        if (bad_n) begin
                            bad_inc = bad_inc + 2'd1;
                        end else begin
                            good_inc = 1'b1;
                        end
                    end
                end else if (b_n != '1) begin
                    b_n = b_n + CNT_ONE;
                end
            end
        end
        efc_sum = {1'b0, err_frame_cnt} + {{(C_CNT_WIDTH-1){1'b0}}, bad_inc};
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            obs_valid     <= 1'b0;
            obs_user      <= 1'b0;
            obs_last      <= 1'b0;
            state         <= ST_IDLE;
            beat_idx      <= '0;
            line_cnt      <= '0;
            lat_lb        <= '0;
            lat_fl        <= '0;
            frame_bad     <= 1'b0;
            sof_pulse     <= 1'b0;
            frame_cnt     <= '0;
            err_frame_cnt <= '0;
            stat_err      <= 4'b0000;
        end else begin
            obs_valid <= accept;
            obs_user  <= s00_axis_tuser;
            obs_last  <= s00_axis_tlast;
            state     <= st_n;
            beat_idx  <= b_n;
            line_cnt  <= line_n;
            lat_lb    <= lb_n;
            lat_fl    <= fl_n;
            frame_bad <= bad_n;
            sof_pulse <= sof_n;
            if (stat_clr) begin
                frame_cnt     <= '0;
                err_frame_cnt <= '0;
                stat_err      <= 4'b0000;
            end else begin
                frame_cnt     <= frame_cnt + {31'd0, good_inc};
                err_frame_cnt <= efc_sum[C_CNT_WIDTH] ? '1 : efc_sum[C_CNT_WIDTH-1:0];
                stat_err      <= stat_err | err_set;
            end
        end
    end

    assign in_frame = (state == ST_ACTIVE);

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// tb/tb_axis_video_frame_checker.sv - directed self-checking bench for axis_video_frame_checker
module tb_axis_video_frame_checker;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_line_beats;
    logic [15:0] cfg_frame_lines;
    logic        stat_clr;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb;
    logic        s_tuser;
    logic        s_tlast;
    logic        m_tvalid;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tready;
    logic [31:0] frame_cnt;
    logic [15:0] err_frame_cnt;
    logic [3:0]  stat_err;
    logic        sof_pulse;
    logic        in_frame;

    logic        rand_mode;
    logic        ready_force;
    logic        rand_bit;
    logic [31:0] seq;
    logic [63:0] first_d;
    logic [73:0] exp_q [$];
    logic [73:0] got [$];
    int          chk_idx;
    int          nvec;
    int          nerr;
    int          sof_cnt;
    int          stall_cnt;
    int          stall0;

    axis_video_frame_checker #(
        .C_AXIS_TDATA_WIDTH(64),
        .C_CNT_WIDTH(16)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .cfg_line_beats(cfg_line_beats),
        .cfg_frame_lines(cfg_frame_lines),
        .stat_clr(stat_clr),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tready(s_tready),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tuser(s_tuser),
        .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tstrb(m_tstrb),
        .m00_axis_tuser(m_tuser),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tready(m_tready),
        .frame_cnt(frame_cnt),
        .err_frame_cnt(err_frame_cnt),
        .stat_err(stat_err),
        .sof_pulse(sof_pulse),
        .in_frame(in_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_tready = rand_mode ? rand_bit : ready_force;

    initial begin
        rand_bit  = 1'b0;
        sof_cnt   = 0;
        stall_cnt = 0;
    end

    always @(posedge clk) begin
        if (m_tvalid && m_tready) got.push_back({m_tstrb, m_tuser, m_tlast, m_tdata});
        if (sof_pulse) sof_cnt++;
        if (s_tvalid && !s_tready) stall_cnt++;
        #1 rand_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_beat(input logic u, input logic l);
        int   t;
        logic rdy;
        t        = 0;
        s_tdata  = {seq, ~seq};
        s_tstrb  = seq[7:0] ^ 8'h3C;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            rdy = s_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 1000);
        if (!rdy) chk("accept_timeout", 128'(rdy), 128'd1);
        else begin
            exp_q.push_back({s_tstrb, u, l, s_tdata});
            seq = seq + 32'd1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_beats(input int n, input logic sof, input logic last);
        for (int i = 0; i < n; i++) send_beat(sof && (i == 0), last && (i == n - 1));
    endtask

    task automatic send_good_frame();
        send_beats(10, 1'b1, 1'b1);
        repeat (9) send_beats(10, 1'b0, 1'b1);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    task automatic check_stream();
        int t;
        t = 0;
        while (got.size() < exp_q.size() && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("stream_len", 128'(got.size()), 128'(exp_q.size()));
        for (int i = chk_idx; i < exp_q.size() && i < got.size(); i++) chk("beat", 128'(got[i]), 128'(exp_q[i]));
        chk_idx = exp_q.size();
    endtask

    initial begin
        nvec = 0; nerr = 0; chk_idx = 0; seq = 32'h1000_0000;
        rst_n = 1'b0; stat_clr = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0;
        s_tuser = 1'b0; s_tlast = 1'b0; cfg_line_beats = 16'd10; cfg_frame_lines = 16'd10;
        rand_mode = 1'b0; ready_force = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_frame_cnt", 128'(frame_cnt), 128'd0);
        chk("rst_stat_err", 128'(stat_err), 128'd0);
        chk("rst_in_frame", 128'(in_frame), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_after_rst", 128'(s_tready), 128'd1);

        // orphan beats in IDLE
        send_beats(5, 1'b0, 1'b0);
        settle();
        chk("idle_orphan_err", 128'(stat_err), 128'd0);
        chk("idle_in_frame", 128'(in_frame), 128'd0);
        chk("idle_sof_cnt", 128'(sof_cnt), 128'd0);

        // three good frames with random downstream ready
        rand_mode = 1'b1;
        repeat (3) send_good_frame();
        settle();
        chk("pass_frame_cnt", 128'(frame_cnt), 128'd3);
        chk("pass_err_frames", 128'(err_frame_cnt), 128'd0);
        chk("pass_stat_err", 128'(stat_err), 128'd0);
        chk("pass_sof_cnt", 128'(sof_cnt), 128'd3);
        chk("pass_in_frame", 128'(in_frame), 128'd0);
        check_stream();

        // orphan beat in DONE
        send_beats(1, 1'b0, 1'b0);
        settle();
        chk("done_orphan_err", 128'(stat_err), 128'h8);
        chk("done_frame_cnt", 128'(frame_cnt), 128'd3);

        // stat_clr coincident with a good frame close
        send_good_frame();
        pulse_clr();
        settle();
        chk("clr_frame_cnt", 128'(frame_cnt), 128'd0);
        chk("clr_err_frames", 128'(err_frame_cnt), 128'd0);
        chk("clr_stat_err", 128'(stat_err), 128'd0);
        chk("clr_sof_cnt", 128'(sof_cnt), 128'd4);

        // short line 4, downstream always ready
        rand_mode = 1'b0;
        check_stream();
        stall0 = stall_cnt;
        send_beats(10, 1'b1, 1'b1);
        repeat (2) send_beats(10, 1'b0, 1'b1);
        send_beats(7, 1'b0, 1'b1);
        repeat (6) send_beats(10, 1'b0, 1'b1);
        settle();
        chk("short_stat_err", 128'(stat_err), 128'h1);
        chk("short_err_frames", 128'(err_frame_cnt), 128'd1);
        chk("short_frame_cnt", 128'(frame_cnt), 128'd0);
        chk("full_rate_stalls", 128'(stall_cnt - stall0), 128'd0);
        pulse_clr();
        chk("clr2_stat_err", 128'(stat_err), 128'd0);
        chk("clr2_err_frames", 128'(err_frame_cnt), 128'd0);

        // long line 2 (12 beats), flag appears on beat 10
        send_beats(10, 1'b1, 1'b1);
        send_beats(9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("long_beat9_err", 128'(stat_err), 128'd0);
        send_beats(1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("long_beat10_err", 128'(stat_err), 128'h2);
        send_beats(2, 1'b0, 1'b1);
        repeat (8) send_beats(10, 1'b0, 1'b1);
        settle();
        chk("long_stat_err", 128'(stat_err), 128'h2);
        chk("long_err_frames", 128'(err_frame_cnt), 128'd1);
        chk("long_frame_cnt", 128'(frame_cnt), 128'd0);
        pulse_clr();

        // early SOF after 6 lines, then a complete frame
        send_beats(10, 1'b1, 1'b1);
        repeat (5) send_beats(10, 1'b0, 1'b1);
        send_good_frame();
        settle();
        chk("early_stat_err", 128'(stat_err), 128'h4);
        chk("early_err_frames", 128'(err_frame_cnt), 128'd1);
        chk("early_frame_cnt", 128'(frame_cnt), 128'd1);
        chk("early_sof_cnt", 128'(sof_cnt), 128'd8);
        check_stream();

        // backpressure: two accepts fill the buffer
        ready_force = 1'b0;
        first_d = {seq, ~seq};
        send_beats(2, 1'b0, 1'b0);
        chk("bp_s_tready", 128'(s_tready), 128'd0);
        chk("bp_m_tvalid", 128'(m_tvalid), 128'd1);
        chk("bp_head", 128'(m_tdata), 128'(first_d));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_head_stable", 128'(m_tdata), 128'(first_d));
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_tready_after_drain", 128'(s_tready), 128'd1);
        check_stream();

        // latency, SOF pulse timing, then reset mid-frame
        ready_force = 1'b0;
        first_d = {seq, ~seq};
        send_beats(1, 1'b1, 1'b0);
        chk("lat_m_tvalid", 128'(m_tvalid), 128'd1);
        chk("lat_m_tdata", 128'(m_tdata), 128'(first_d));
        chk("lat_m_tuser", 128'(m_tuser), 128'd1);
        chk("sof_not_yet", 128'(sof_pulse), 128'd0);
        @(posedge clk);
        #1;
        chk("sof_pulse", 128'(sof_pulse), 128'd1);
        chk("in_frame_active", 128'(in_frame), 128'd1);
        send_beats(1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("midrst_s_tready", 128'(s_tready), 128'd0);
        chk("midrst_in_frame", 128'(in_frame), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_s_tready", 128'(s_tready), 128'd1);
        chk("postrst_m_tvalid", 128'(m_tvalid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
